btn_event_gen: RTL
==================

BTN_EVENT_GEN -- requirements
Module: btn_event_gen

Interface
REQ-001 SHALL have parameter NBTN, default 2: number of independent button channels.
REQ-002 SHALL have parameter TICK_DIV, default 125000: CLK cycles per sample tick (1 ms at 125 MHz); legal range >= 2.
REQ-003 SHALL have parameter DB_SAMPLES, default 10: consecutive differing ticks needed to accept a new level; legal range 1..255.
REQ-004 SHALL have parameter RPT_DELAY, default 500: ticks of continuous hold before the first repeat pulse.
REQ-005 SHALL have parameter RPT_PERIOD, default 100: ticks between subsequent repeat pulses.
REQ-006 SHALL have port CLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 SHALL have port RST_N, input, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have port BTN, input, NBTN bits: raw asynchronous, bouncy button levels (1 = pressed).
REQ-009 SHALL have port LEVEL, output, NBTN bits: debounced button level.
REQ-010 SHALL have port PRESS, output, NBTN bits: one-cycle event pulse per accepted press or repeat; feeds the pattern-select counter.
REQ-011 SHALL have port RELEASE, output, NBTN bits: one-cycle pulse per accepted release.

Function
REQ-012 SHALL pass each BTN bit through a 2-flop synchronizer before any other use.
REQ-013 SHALL run one shared prescaler counting 0..TICK_DIV-1, asserting an internal tick for exactly one cycle when it equals TICK_DIV-1, then wrapping to 0.
REQ-014 SHALL keep a per-channel stability counter: on tick, if the synchronized input differs from LEVEL, increment; if they match, clear to 0.
REQ-015 SHALL update LEVEL to the synchronized value and clear the stability counter on the tick where the counter would reach DB_SAMPLES.
REQ-016 SHALL ignore bounce: any matching sample before DB_SAMPLES is reached restarts the count from 0.
REQ-017 SHALL assert PRESS[i] for exactly the one cycle in which LEVEL[i] first reads 1 after a 0->1 update.
REQ-018 SHALL assert RELEASE[i] for exactly the one cycle in which LEVEL[i] first reads 0 after a 1->0 update.
REQ-019 SHALL implement a per-channel FSM: REL (LEVEL=0), HOLD (counting RPT_DELAY ticks), RPT (counting RPT_PERIOD ticks).
REQ-020 SHALL use these FSM transitions: REL->HOLD on LEVEL rise; HOLD->RPT and PRESS pulse when the hold count reaches RPT_DELAY; in RPT, PRESS pulse and count reload every RPT_PERIOD ticks; any state->REL on LEVEL fall.
REQ-021 SHALL handle channels independently: simultaneous events on several channels all pulse in the same cycle, and priority between channels is the consumer's job.
REQ-022 SHALL give release precedence: a repeat pulse never coincides with or follows a RELEASE pulse of the same channel.
REQ-023 SHALL saturate internal hold and repeat counters, never wrapping them, and size every counter by $clog2 of its parameter.

Reset
REQ-024 SHALL, while RST_N=0 at a CLK edge, clear the prescaler, synchronizers, stability counters, LEVEL, PRESS and RELEASE to 0 and force every FSM to REL.
REQ-025 SHALL, on reset asserted mid-hold or mid-debounce, emit no PRESS or RELEASE pulse in that cycle or the following cycle.
REQ-026 SHALL, if a button is already held when reset deasserts, treat it as a fresh press: PRESS after DB_SAMPLES ticks.

Configuration
REQ-027 SHALL, with macro BTN_AUTOREPEAT_EN defined, compile in the HOLD/RPT repeat behaviour of REQ-019..REQ-020.
REQ-028 SHALL, with BTN_AUTOREPEAT_EN undefined, omit the repeat FSM and counters, so PRESS pulses exactly once per accepted press and RPT_DELAY and RPT_PERIOD are unused.

Verification (TICK_DIV=4, DB_SAMPLES=3, RPT_DELAY=5, RPT_PERIOD=2, NBTN=2)
REQ-029 SHALL cover clean press: BTN[0] 0->1 held -> LEVEL[0]=1 and a single PRESS[0] pulse within 3 ticks plus 3 cycles (at most 15 cycles); BTN[1] outputs stay 0.
REQ-030 SHALL cover bounce: BTN[0] toggling every 5 cycles for 60 cycles, then low -> LEVEL[0] stays 0, and PRESS[0] and RELEASE[0] never assert.
REQ-031 SHALL cover auto-repeat (macro defined): BTN[0] held 40 ticks -> PRESS pulses at acceptance, then +5 ticks, then every 2 ticks; release -> one RELEASE[0] and no further PRESS.
REQ-032 SHALL cover the macro undefined: same stimulus as REQ-031 -> exactly one PRESS[0] and one RELEASE[0].
REQ-033 SHALL cover simultaneous events: BTN=2'b11 on the same cycle -> PRESS=2'b11 in one cycle; then BTN[1] released alone -> RELEASE=2'b10 only.
REQ-034 SHALL cover reset mid-operation: RST_N=0 for 1 cycle during RPT -> all outputs 0 next cycle; button still held -> PRESS reasserts after 3 ticks.

Source files
------------

// File: rtl/btn_event_gen_if.sv
// Button channel bundle: raw button levels in, debounced level and event pulses out.
interface btn_event_gen_if #(
    parameter int NBTN = 2
);
    logic [NBTN-1:0] BTN;
    logic [NBTN-1:0] LEVEL;
    logic [NBTN-1:0] PRESS;
    logic [NBTN-1:0] RELEASE;

    modport master (output BTN, input LEVEL, input PRESS, input RELEASE);
    modport slave  (input BTN, output LEVEL, output PRESS, output RELEASE);
endinterface

// File: rtl/btn_event_gen.sv
// btn_event_gen: per-channel button synchronizer, tick-based debouncer and
// press/release event generator. Define BTN_AUTOREPEAT_EN to compile in the
// hold/repeat FSM that re-issues PRESS while a button stays down; without it
// PRESS fires exactly once per accepted press.
module btn_event_gen #(
    parameter int NBTN       = 2,
    parameter int TICK_DIV   = 125000,
    parameter int DB_SAMPLES = 10,
    parameter int RPT_DELAY  = 500,
    parameter int RPT_PERIOD = 100
) (
    input  logic              CLK,
    input  logic              RST_N,
    btn_event_gen_if.slave    bus
);
    localparam int PW  = $clog2(TICK_DIV);
    localparam int DBW = (DB_SAMPLES > 1) ? $clog2(DB_SAMPLES) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_SAMPLES - 1);

    if (TICK_DIV < 2 || DB_SAMPLES < 1 || DB_SAMPLES > 255 || RPT_DELAY < 1 || RPT_PERIOD < 1) begin : g_bad_param
        $error("btn_event_gen: illegal parameter value");
    end

    logic [NBTN-1:0] sync1_q, sync2_q;
    logic [NBTN-1:0] level_q, level_d;
    logic [NBTN-1:0] press_q, press_d;
    logic [NBTN-1:0] release_q, release_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic            tick_s;
    logic [DBW-1:0]  stab_q [NBTN];
    logic [DBW-1:0]  stab_d [NBTN];
    logic [NBTN-1:0] accept_s, rise_s, fall_s;

    // Shared prescaler: one-cycle tick on the last count, then wrap to zero.
    always_comb begin
        tick_s = (pre_q == PRE_LAST);
        if (tick_s) begin
            pre_d = {PW{1'b0}};
        end else begin
            pre_d = pre_q + PW'(1'b1);
        end
    end

    // Debounce: count consecutive differing ticks; any matching tick restarts the count.
    always_comb begin
        accept_s = {NBTN{1'b0}};
        for (int i = 0; i < NBTN; i++) begin
            stab_d[i] = stab_q[i];
            if (tick_s) begin
                if (sync2_q[i] != level_q[i]) begin
                    if (stab_q[i] == DB_LAST) begin
                        accept_s[i] = 1'b1;
                        stab_d[i]   = {DBW{1'b0}};
                    end else begin
                        stab_d[i]   = stab_q[i] + DBW'(1'b1);
                    end
                end else begin
                    stab_d[i] = {DBW{1'b0}};
                end
            end else begin
                stab_d[i] = stab_q[i];
            end
        end
        rise_s  = accept_s & sync2_q;
        fall_s  = accept_s & ~sync2_q;
        level_d = level_q ^ accept_s;
    end

`ifdef BTN_AUTOREPEAT_EN
    // One shared counter serves both the hold delay and the repeat period.
    localparam int RMAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [RW-1:0] DLY_LAST = RW'(RPT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(RPT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_REL  = 2'd0,
        ST_HOLD = 2'd1,
        ST_RPT  = 2'd2
    } rpt_state_e;

    rpt_state_e      st_q   [NBTN];
    rpt_state_e      st_d   [NBTN];
    logic [RW-1:0]   rcnt_q [NBTN];
    logic [RW-1:0]   rcnt_d [NBTN];
    logic [NBTN-1:0] rpt_s;

    // Repeat FSM state and tick counter registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < NBTN; i++) begin
                st_q[i]   <= ST_REL;
                rcnt_q[i] <= {RW{1'b0}};
            end
        end else begin
            st_q   <= st_d;
            rcnt_q <= rcnt_d;
        end
    end

    // Repeat FSM transitions; a level fall always wins and returns to REL.
    always_comb begin
        for (int i = 0; i < NBTN; i++) begin
            st_d[i]   = st_q[i];
            rcnt_d[i] = rcnt_q[i];
            case (st_q[i])
                ST_REL: begin
                    if (rise_s[i]) begin
                        st_d[i]   = ST_HOLD;
                        rcnt_d[i] = {RW{1'b0}};
                    end else begin
                        st_d[i]   = ST_REL;
                    end
                end
                ST_HOLD, ST_RPT: begin
                    if (fall_s[i]) begin
                        st_d[i]   = ST_REL;
                        rcnt_d[i] = {RW{1'b0}};
                    end else if (tick_s) begin
                        if (rcnt_q[i] == ((st_q[i] == ST_HOLD) ? DLY_LAST : PER_LAST)) begin
                            st_d[i]   = ST_RPT;
                            rcnt_d[i] = {RW{1'b0}};
                        end else if (rcnt_q[i] < RW'(RMAX - 1)) begin
                            rcnt_d[i] = rcnt_q[i] + RW'(1'b1);
                        end else begin
                            rcnt_d[i] = rcnt_q[i];
                        end
                    end else begin
                        st_d[i] = st_q[i];
                    end
                end
                default: begin
                    st_d[i]   = ST_REL;
                    rcnt_d[i] = {RW{1'b0}};
                end
            endcase
        end
    end

    // Repeat pulse when the hold or period count completes, unless the channel is releasing.
    always_comb begin
        rpt_s = {NBTN{1'b0}};
        for (int i = 0; i < NBTN; i++) begin
            case (st_q[i])
                ST_HOLD: rpt_s[i] = tick_s && !fall_s[i] && (rcnt_q[i] == DLY_LAST);
                ST_RPT:  rpt_s[i] = tick_s && !fall_s[i] && (rcnt_q[i] == PER_LAST);
                default: rpt_s[i] = 1'b0;
            endcase
        end
    end

    // Press events combine accepted rises with repeat pulses.
    always_comb begin
        press_d   = rise_s | rpt_s;
        release_d = fall_s;
    end
`else
    // Press events are accepted rises only.
    always_comb begin
        press_d   = rise_s;
        release_d = fall_s;
    end
`endif

    // Synchronizers, prescaler, debounce state and registered outputs.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync1_q   <= {NBTN{1'b0}};
            sync2_q   <= {NBTN{1'b0}};
            pre_q     <= {PW{1'b0}};
            level_q   <= {NBTN{1'b0}};
            press_q   <= {NBTN{1'b0}};
            release_q <= {NBTN{1'b0}};
            for (int i = 0; i < NBTN; i++) begin
                stab_q[i] <= {DBW{1'b0}};
            end
        end else begin
            sync1_q   <= bus.BTN;
            sync2_q   <= sync1_q;
            pre_q     <= pre_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            stab_q    <= stab_d;
        end
    end

    assign bus.LEVEL   = level_q;
    assign bus.PRESS   = press_q;
    assign bus.RELEASE = release_q;

endmodule
